// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: compacts valid fetch slots into a
// circular array and presents the oldest DECODE_WIDTH entries in program order.
module fetch_buffer #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH-1:0]                 in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]           in_instr,
  input  logic [FETCH_WIDTH-1:0][63:0]           in_pc,
  output logic                                   in_ready,
  output logic [DECODE_WIDTH-1:0]                out_valid,
  output logic [DECODE_WIDTH-1:0][31:0]          out_instr,
  output logic [DECODE_WIDTH-1:0][63:0]          out_pc,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]      deq_num,
  output logic [$clog2(DEPTH+1)-1:0]             count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $clog2(DECODE_WIDTH+1);

  function automatic logic [CW-1:0] popcount(input logic [FETCH_WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  logic [31:0]                   instr_mem_r [DEPTH];
  logic [63:0]                   pc_mem_r    [DEPTH];
  logic [PW-1:0]                 head_r;
  logic [PW-1:0]                 tail_r;
  logic [CW-1:0]                 count_r;
  logic                          in_ready_s;
  logic                          enq_fire_s;
  logic [CW-1:0]                 enq_cnt_s;
  logic [CW-1:0]                 deq_eff_s;
  logic [FETCH_WIDTH-1:0][PW-1:0] wr_idx_s;

  // Admission and dequeue control, derived from registered occupancy only
  always_comb begin
    in_ready_s = (count_r <= CW'(DEPTH - FETCH_WIDTH));
    enq_fire_s = in_ready_s && !flush;
    if (enq_fire_s) begin
      enq_cnt_s = popcount(in_valid);
    end else begin
      enq_cnt_s = '0;
    end
    // An over-request from decode is clamped so occupancy can never underflow
    if (CW'(deq_num) > count_r) begin
      deq_eff_s = count_r;
    end else begin
      deq_eff_s = CW'(deq_num);
    end
  end

  // Compaction: each valid slot lands after all lower-numbered valid slots
  always_comb begin
    logic [PW-1:0] off_v;
    off_v = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx_s[i] = tail_r + off_v;
      off_v       = off_v + PW'(in_valid[i]);
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PW'(deq_eff_s);
      tail_r  <= tail_r + PW'(enq_cnt_s);
      count_r <= count_r + enq_cnt_s - deq_eff_s;
    end
  end

  // Entry storage; contents survive reset and flush by design
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (enq_fire_s && in_valid[i]) begin
        instr_mem_r[wr_idx_s[i]] <= in_instr[i];
        pc_mem_r[wr_idx_s[i]]    <= in_pc[i];
      end
    end
  end

  // Decode-facing read of the oldest entries
  always_comb begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      out_valid[i] = (count_r > CW'(i));
      out_instr[i] = instr_mem_r[head_r + PW'(i)];
      out_pc[i]    = pc_mem_r[head_r + PW'(i)];
    end
  end

  assign in_ready = in_ready_s;
  assign count    = count_r;

  fetch_buffer_chk #(
    .CW    (CW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .deq_num (deq_num),
    .count   (count_r)
  );

endmodule

// Protocol checks for fetch_buffer: decode must not consume more than is held.
module fetch_buffer_chk #(
  parameter int CW    = 4,
  parameter int DW    = 2,
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          reset,
  input logic [DW-1:0] deq_num,
  input logic [CW-1:0] count
);

  deq_within_count: assert property (@(posedge clk) disable iff (reset)
    CW'(deq_num) <= count);

  count_within_depth: assert property (@(posedge clk) disable iff (reset)
    count <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (FETCH_WIDTH=DECODE_WIDTH=2, DEPTH=8).
module tb_fetch_buffer;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       in_valid = 2'b00;
  logic [1:0][31:0] in_instr = '0;
  logic [1:0][63:0] in_pc = '0;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_instr;
  logic [1:0][63:0] out_pc;
  logic [1:0]       deq_num = 2'd0;
  logic [3:0]       count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_buffer #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .deq_num   (deq_num),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [63:0] p);
    return p[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [1:0] d);
    in_valid    = v;
    in_pc[0]    = p0;
    in_pc[1]    = p1;
    in_instr[0] = mk_instr(p0);
    in_instr[1] = mk_instr(p1);
    deq_num     = d;
    flush       = 1'b0;
  endtask

  task automatic idle(input logic [1:0] d);
    offer(2'b00, 64'h0, 64'h0, d);
  endtask

  initial begin
    logic [63:0] base;
    logic [63:0] exp0;

    #2;
    check_val("rst_count", 64'(count), 64'd0);
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // basic full group
    offer(2'b11, 64'h1000, 64'h1004, 2'd0);
    step();
    idle(2'd0);
    check_val("t1_count", 64'(count), 64'd2);
    check_val("t1_valid", 64'(out_valid), 64'd3);
    check_val("t1_pc0", out_pc[0], 64'h1000);
    check_val("t1_pc1", out_pc[1], 64'h1004);
    check_val("t1_instr0", 64'(out_instr[0]), 64'(mk_instr(64'h1000)));
    check_val("t1_instr1", 64'(out_instr[1]), 64'(mk_instr(64'h1004)));
    check_val("t1_ready", 64'(in_ready), 64'd1);
    idle(2'd2);
    step();
    idle(2'd0);
    check_val("t1_drain", 64'(count), 64'd0);

    // compaction of sparse groups
    offer(2'b10, 64'h2000, 64'h2004, 2'd0);
    step();
    offer(2'b01, 64'h2008, 64'h200c, 2'd0);
    step();
    idle(2'd0);
    check_val("t2_pc0", out_pc[0], 64'h2004);
    check_val("t2_pc1", out_pc[1], 64'h2008);
    check_val("t2_count", 64'(count), 64'd2);
    idle(2'd2);
    step();
    idle(2'd0);

    // fill to full, overflow ignored, boundary at 7/6
    for (int g = 0; g < 4; g++) begin
      offer(2'b11, 64'h3000 + 64'(8 * g), 64'h3004 + 64'(8 * g), 2'd0);
      step();
      if (g == 2) begin
        check_val("t3_ready_at6", 64'(in_ready), 64'd1);
      end
    end
    idle(2'd0);
    check_val("t3_full_count", 64'(count), 64'd8);
    check_val("t3_full_ready", 64'(in_ready), 64'd0);
    offer(2'b11, 64'h3100, 64'h3104, 2'd0);
    step();
    idle(2'd0);
    check_val("t3_ovf_count", 64'(count), 64'd8);
    check_val("t3_ovf_pc0", out_pc[0], 64'h3000);
    idle(2'd1);
    step();
    idle(2'd0);
    check_val("t3_c7_count", 64'(count), 64'd7);
    check_val("t3_c7_ready", 64'(in_ready), 64'd0);
    check_val("t3_c7_pc0", out_pc[0], 64'h3004);
    idle(2'd1);
    step();
    idle(2'd0);
    check_val("t3_c6_count", 64'(count), 64'd6);
    check_val("t3_c6_ready", 64'(in_ready), 64'd1);
    check_val("t3_c6_pc0", out_pc[0], 64'h3008);
    check_val("t3_c6_pc1", out_pc[1], 64'h300c);
    for (int k = 0; k < 3; k++) begin
      idle(2'd2);
      step();
    end
    idle(2'd0);
    check_val("t3_drain", 64'(count), 64'd0);

    // streaming through the wrap with an odd alignment so groups straddle 7->0
    base = 64'h4000;
    offer(2'b01, base, 64'h0, 2'd0);
    step();
    offer(2'b11, base + 64'd4, base + 64'd8, 2'd0);
    step();
    for (int j = 0; j < 9; j++) begin
      exp0 = base + 64'(8 * j);
      check_val("t4_pc0", out_pc[0], exp0);
      check_val("t4_pc1", out_pc[1], exp0 + 64'd4);
      check_val("t4_count", 64'(count), 64'd3);
      offer(2'b11, base + 64'(4 * (2 * j + 3)), base + 64'(4 * (2 * j + 4)), 2'd2);
      step();
    end
    idle(2'd0);
    check_val("t4_tail_pc0", out_pc[0], base + 64'd72);
    check_val("t4_tail_count", 64'(count), 64'd3);
    idle(2'd2);
    step();
    idle(2'd1);
    step();
    idle(2'd0);
    check_val("t4_drain", 64'(count), 64'd0);

    // flush discards both the queue and the same-cycle enqueue/dequeue
    offer(2'b11, 64'h5000, 64'h5004, 2'd0);
    step();
    offer(2'b11, 64'h5008, 64'h500c, 2'd0);
    step();
    offer(2'b01, 64'h5010, 64'h0, 2'd0);
    step();
    idle(2'd0);
    check_val("t5_pre_count", 64'(count), 64'd5);
    offer(2'b11, 64'h5100, 64'h5104, 2'd2);
    flush = 1'b1;
    step();
    idle(2'd0);
    check_val("t5_count", 64'(count), 64'd0);
    check_val("t5_valid", 64'(out_valid), 64'd0);
    check_val("t5_ready", 64'(in_ready), 64'd1);
    offer(2'b11, 64'h6000, 64'h6004, 2'd0);
    step();
    idle(2'd0);
    check_val("t5_refill_pc0", out_pc[0], 64'h6000);
    check_val("t5_refill_pc1", out_pc[1], 64'h6004);
    check_val("t5_refill_count", 64'(count), 64'd2);
    idle(2'd2);
    step();
    idle(2'd0);

    // asynchronous reset between edges
    offer(2'b11, 64'h7000, 64'h7004, 2'd0);
    step();
    idle(2'd0);
    check_val("t6_pre_count", 64'(count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_async_count", 64'(count), 64'd0);
    check_val("t6_async_valid", 64'(out_valid), 64'd0);
    check_val("t6_async_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    offer(2'b11, 64'h7100, 64'h7104, 2'd0);
    step();
    idle(2'd0);
    check_val("t6_refill_count", 64'(count), 64'd2);
    check_val("t6_refill_pc0", out_pc[0], 64'h7100);
    check_val("t6_refill_pc1", out_pc[1], 64'h7104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
